// File: rtl/pc_control_pkg.sv
// Shared ISA definitions for the fetch/PC control path: condition codes,
// flag bit positions, PC control states and the reset fetch address.
package pc_control_pkg;

  localparam int          PC_W     = 16;
  localparam logic [15:0] RESET_PC = 16'h0000;

  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 0;

  typedef enum logic [2:0] {
    COND_NE = 3'b000,
    COND_EQ = 3'b001,
    COND_GT = 3'b010,
    COND_LT = 3'b011,
    COND_GE = 3'b100,
    COND_LE = 3'b101,
    COND_OV = 3'b110,
    COND_UN = 3'b111
  } cond_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

endpackage

// File: rtl/add_16bit.sv
// Plain 16-bit modulo adder shared by every PC and counter increment.
module add_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/branch_cond.sv
// Evaluates a 3-bit branch condition code against the Z/V/N flag register.
module branch_cond
  import pc_control_pkg::*;
(
  input  logic [2:0] condition,
  input  logic [2:0] flags,
  output logic       cond_true
);

  logic flagZ, flagV, flagN;

  assign flagZ = flags[FLAG_Z];
  assign flagV = flags[FLAG_V];
  assign flagN = flags[FLAG_N];

  always_comb begin
    cond_true = 1'b0;
    case (cond_e'(condition))
      COND_NE: cond_true = ~flagZ;
      COND_EQ: cond_true = flagZ;
      COND_GT: cond_true = ~flagZ & ~flagN;
      COND_LT: cond_true = flagN;
      COND_GE: cond_true = flagZ | (~flagZ & ~flagN);
      COND_LE: cond_true = flagN | flagZ;
      COND_OV: cond_true = flagV;
      COND_UN: cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_control.sv
// PC register, branch resolution in ID (one-bubble flush), HLT handling and a
// saturating taken-branch counter.
module pc_control
  import pc_control_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch,
  input  logic        branch_reg,
  input  logic        hlt,
  input  logic [2:0]  condition,
  input  logic [2:0]  flags,
  input  logic [8:0]  imm,
  input  logic [15:0] id_pc,
  input  logic [15:0] reg_target,
  output logic [15:0] pc,
  output logic [15:0] pc_plus2,
  output logic        flush,
  output logic        halted,
  output logic [15:0] taken_cnt
);

  state_e      state, stateNext;
  logic [15:0] pcReg, pcNext;
  logic [15:0] takenCnt, cntNext;
  logic [15:0] pcInc, idPcPlus2, immOff, branchTarget, target, cntInc;
  logic        condTrue, running, taken, goHalt;

  branch_cond uCond (
    .condition (condition),
    .flags     (flags),
    .cond_true (condTrue)
  );

  // Word offset: sign-extend the 9-bit immediate and scale by two.
  assign immOff = {{6{imm[8]}}, imm, 1'b0};

  add_16bit uPcInc  (.a(pcReg),     .b(16'h0002), .sum(pcInc));
  add_16bit uIdInc  (.a(id_pc),     .b(16'h0002), .sum(idPcPlus2));
  add_16bit uTarget (.a(idPcPlus2), .b(immOff),   .sum(branchTarget));
  add_16bit uCntInc (.a(takenCnt),  .b(16'h0001), .sum(cntInc));

  assign target  = branch_reg ? reg_target : branchTarget;
  assign running = (state == ST_RUN);
  assign taken   = (branch | branch_reg) & condTrue & ~stall & running;
  assign goHalt  = hlt & ~stall & ~taken & running;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_RUN;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      ST_RUN:  if (goHalt) stateNext = ST_HALT;
      ST_HALT: stateNext = ST_HALT;
      default: stateNext = ST_RUN;
    endcase
  end

  // Reset is folded in so no flush escapes while rst_n is held low.
  always_comb begin
    flush  = taken & rst_n;
    halted = (state == ST_HALT);
  end

  always_comb begin
    pcNext = pcReg;
    if (running) begin
      if (taken)               pcNext = target;
      else if (stall | goHalt) pcNext = pcReg;
      else                     pcNext = pcInc;
    end
  end

  always_comb begin
    cntNext = takenCnt;
    if (taken && (takenCnt != 16'hFFFF)) cntNext = cntInc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcReg    <= RESET_PC;
      takenCnt <= 16'h0000;
    end else begin
      pcReg    <= pcNext;
      takenCnt <= cntNext;
    end
  end

  assign pc        = pcReg;
  assign pc_plus2  = pcInc;
  assign taken_cnt = takenCnt;

endmodule

// File: tb/tb_pc_control.sv
// Scoreboard bench for pc_control: per-cycle stimulus tables, expected state
// queued at drive time and compared after the clock edge.
module tb_pc_control;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, branch, branch_reg, hlt;
  logic [2:0]  condition, flags;
  logic [8:0]  imm;
  logic [15:0] id_pc, reg_target;
  logic [15:0] pc, pc_plus2, taken_cnt;
  logic        flush, halted;

  int nCmp = 0;
  int nBad = 0;

  typedef struct {
    logic        b, br, h, st;
    logic [2:0]  cond, fl;
    logic [8:0]  imm;
    logic [15:0] idpc, rt;
    logic        expFlush;
    logic [15:0] expPc;
    logic        expHalt;
    logic [15:0] expCnt;
  } vec_t;

  typedef struct {
    logic [15:0] pc;
    logic [15:0] pcp2;
    logic        halted;
    logic [15:0] cnt;
  } exp_t;

  exp_t sbQ[$];

  pc_control dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall      (stall),
    .branch     (branch),
    .branch_reg (branch_reg),
    .hlt        (hlt),
    .condition  (condition),
    .flags      (flags),
    .imm        (imm),
    .id_pc      (id_pc),
    .reg_target (reg_target),
    .pc         (pc),
    .pc_plus2   (pc_plus2),
    .flush      (flush),
    .halted     (halted),
    .taken_cnt  (taken_cnt)
  );

  always #5 clk = ~clk;

  function automatic vec_t mkv(input logic b, br, h, st, input logic [2:0] cond, fl,
                               input logic [8:0] im, input logic [15:0] idpc, rt,
                               input logic f, input logic [15:0] p, input logic hl,
                               input logic [15:0] cnt);
    vec_t v;
    v.b = b; v.br = br; v.h = h; v.st = st; v.cond = cond; v.fl = fl; v.imm = im;
    v.idpc = idpc; v.rt = rt; v.expFlush = f; v.expPc = p; v.expHalt = hl; v.expCnt = cnt;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    branch = v.b; branch_reg = v.br; hlt = v.h; stall = v.st;
    condition = v.cond; flags = v.fl; imm = v.imm; id_pc = v.idpc; reg_target = v.rt;
  endtask

  task automatic idle();
    branch = 0; branch_reg = 0; hlt = 0; stall = 0;
    condition = 0; flags = 0; imm = 0; id_pc = 0; reg_target = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    vec_t stim[$];
    vec_t v;
    exp_t e;
    rst_n = 1'b0;
    idle();
    branch = 1'b1; condition = 3'b111;
    #2;
    nCmp++;
    if ({pc, halted, taken_cnt, flush} !== {16'h0000, 1'b0, 16'h0000, 1'b0}) begin
      nBad++;
      $display("FAIL in_reset: pc=%h halted=%b cnt=%h flush=%b, want 0000 0 0000 0", pc, halted, taken_cnt, flush);
    end
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    #1;
    nCmp++;
    if ({pc, flush} !== {16'h0000, 1'b0}) begin
      nBad++;
      $display("FAIL reset_release: pc=%h flush=%b, want 0000 0", pc, flush);
    end
    for (int i = 1; i <= 3; i++)
      stim.push_back(mkv(0,0,0,0, 3'd0, 3'd0, 9'd0, 16'h0, 16'h0, 0, 16'(2*i), 0, 16'h0));
    while (stim.size() > 0) begin
      v = stim.pop_front();
      drive(v);
      sbQ.push_back('{v.expPc, v.expPc + 16'd2, v.expHalt, v.expCnt});
      #1;
      nCmp++;
      if (flush !== v.expFlush) begin nBad++; $display("FAIL run_flush: flush=%b want %b", flush, v.expFlush); end
      tick();
      e = sbQ.pop_front();
      nCmp++;
      if ({pc, pc_plus2, halted, taken_cnt} !== {e.pc, e.pcp2, e.halted, e.cnt}) begin
        nBad++;
        $display("FAIL run_pc: pc=%h p2=%h h=%b cnt=%h want %h %h %b %h", pc, pc_plus2, halted, taken_cnt, e.pc, e.pcp2, e.halted, e.cnt);
      end
    end
  endtask

  task automatic test_branch_b();
    vec_t stim[$];
    vec_t v;
    exp_t e;
    stim.push_back(mkv(1,0,0,0, 3'b001, 3'b100, 9'h1FE, 16'h0010, 16'h0, 1, 16'h000E, 0, 16'd1));
    while (stim.size() > 0) begin
      v = stim.pop_front();
      drive(v);
      sbQ.push_back('{v.expPc, v.expPc + 16'd2, v.expHalt, v.expCnt});
      #1;
      nCmp++;
      if (flush !== v.expFlush) begin nBad++; $display("FAIL b_flush: flush=%b want %b", flush, v.expFlush); end
      tick();
      e = sbQ.pop_front();
      nCmp++;
      if ({pc, pc_plus2, halted, taken_cnt} !== {e.pc, e.pcp2, e.halted, e.cnt}) begin
        nBad++;
        $display("FAIL b_target: pc=%h p2=%h h=%b cnt=%h want %h %h %b %h", pc, pc_plus2, halted, taken_cnt, e.pc, e.pcp2, e.halted, e.cnt);
      end
    end
  endtask

  task automatic test_not_taken_then_br();
    vec_t stim[$];
    vec_t v;
    exp_t e;
    stim.push_back(mkv(1,0,0,0, 3'b010, 3'b001, 9'h004, 16'h000E, 16'h0, 0, 16'h0010, 0, 16'd1));
    stim.push_back(mkv(0,1,0,0, 3'b111, 3'b000, 9'h000, 16'h0010, 16'h1234, 1, 16'h1234, 0, 16'd2));
    while (stim.size() > 0) begin
      v = stim.pop_front();
      drive(v);
      sbQ.push_back('{v.expPc, v.expPc + 16'd2, v.expHalt, v.expCnt});
      #1;
      nCmp++;
      if (flush !== v.expFlush) begin nBad++; $display("FAIL nt_br_flush: flush=%b want %b", flush, v.expFlush); end
      tick();
      e = sbQ.pop_front();
      nCmp++;
      if ({pc, pc_plus2, halted, taken_cnt} !== {e.pc, e.pcp2, e.halted, e.cnt}) begin
        nBad++;
        $display("FAIL nt_br_pc: pc=%h p2=%h h=%b cnt=%h want %h %h %b %h", pc, pc_plus2, halted, taken_cnt, e.pc, e.pcp2, e.halted, e.cnt);
      end
    end
  endtask

  task automatic test_stall_branch();
    vec_t stim[$];
    vec_t v;
    exp_t e;
    stim.push_back(mkv(0,1,0,1, 3'b111, 3'b000, 9'h0, 16'h0, 16'h0100, 0, 16'h1234, 0, 16'd2));
    stim.push_back(mkv(0,1,0,1, 3'b111, 3'b000, 9'h0, 16'h0, 16'h0100, 0, 16'h1234, 0, 16'd2));
    stim.push_back(mkv(0,1,0,0, 3'b111, 3'b000, 9'h0, 16'h0, 16'h0100, 1, 16'h0100, 0, 16'd3));
    while (stim.size() > 0) begin
      v = stim.pop_front();
      drive(v);
      sbQ.push_back('{v.expPc, v.expPc + 16'd2, v.expHalt, v.expCnt});
      #1;
      nCmp++;
      if (flush !== v.expFlush) begin nBad++; $display("FAIL stall_flush: flush=%b want %b", flush, v.expFlush); end
      tick();
      e = sbQ.pop_front();
      nCmp++;
      if ({pc, pc_plus2, halted, taken_cnt} !== {e.pc, e.pcp2, e.halted, e.cnt}) begin
        nBad++;
        $display("FAIL stall_pc: pc=%h p2=%h h=%b cnt=%h want %h %h %b %h", pc, pc_plus2, halted, taken_cnt, e.pc, e.pcp2, e.halted, e.cnt);
      end
    end
  endtask

  task automatic test_halt();
    vec_t stim[$];
    vec_t v;
    exp_t e;
    stim.push_back(mkv(0,1,0,0, 3'b111, 3'b000, 9'h0, 16'h0, 16'h0008, 1, 16'h0008, 0, 16'd4));
    stim.push_back(mkv(0,0,1,0, 3'b000, 3'b000, 9'h0, 16'h0008, 16'h0, 0, 16'h0008, 1, 16'd4));
    for (int i = 0; i < 5; i++)
      stim.push_back(mkv(1,0,1,0, 3'b111, 3'b000, 9'h010, 16'h0040, 16'h0, 0, 16'h0008, 1, 16'd4));
    while (stim.size() > 0) begin
      v = stim.pop_front();
      drive(v);
      sbQ.push_back('{v.expPc, v.expPc + 16'd2, v.expHalt, v.expCnt});
      #1;
      nCmp++;
      if (flush !== v.expFlush) begin nBad++; $display("FAIL halt_flush: flush=%b want %b", flush, v.expFlush); end
      tick();
      e = sbQ.pop_front();
      nCmp++;
      if ({pc, pc_plus2, halted, taken_cnt} !== {e.pc, e.pcp2, e.halted, e.cnt}) begin
        nBad++;
        $display("FAIL halt_pc: pc=%h p2=%h h=%b cnt=%h want %h %h %b %h", pc, pc_plus2, halted, taken_cnt, e.pc, e.pcp2, e.halted, e.cnt);
      end
    end
    idle();
    rst_n = 1'b0;
    #1;
    nCmp++;
    if ({pc, halted, taken_cnt} !== {16'h0000, 1'b0, 16'h0000}) begin
      nBad++;
      $display("FAIL halt_async_rst: pc=%h halted=%b cnt=%h, want 0000 0 0000", pc, halted, taken_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    nCmp++;
    if ({pc, halted} !== {16'h0002, 1'b0}) begin
      nBad++;
      $display("FAIL halt_restart: pc=%h halted=%b, want 0002 0", pc, halted);
    end
  endtask

  task automatic test_reset_mid_stall();
    stall = 1'b1;
    tick();
    nCmp++;
    if (pc !== 16'h0002) begin nBad++; $display("FAIL stall_hold: pc=%h want 0002", pc); end
    rst_n = 1'b0;
    #1;
    nCmp++;
    if (pc !== 16'h0000) begin nBad++; $display("FAIL stall_async_rst: pc=%h want 0000", pc); end
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    tick();
    nCmp++;
    if (pc !== 16'h0002) begin nBad++; $display("FAIL stall_restart: pc=%h want 0002", pc); end
  endtask

  task automatic test_saturate_wrap();
    vec_t stim[$];
    vec_t v;
    exp_t e;
    force dut.takenCnt = 16'hFFFE;
    #1;
    release dut.takenCnt;
    stim.push_back(mkv(1,0,0,0, 3'b111, 3'b000, 9'h000, 16'hFFFE, 16'h0, 1, 16'h0000, 0, 16'hFFFF));
    stim.push_back(mkv(1,0,0,0, 3'b111, 3'b000, 9'h000, 16'hFFFE, 16'h0, 1, 16'h0000, 0, 16'hFFFF));
    stim.push_back(mkv(0,1,0,0, 3'b111, 3'b000, 9'h000, 16'h0, 16'hFFFE, 1, 16'hFFFE, 0, 16'hFFFF));
    stim.push_back(mkv(0,0,0,0, 3'b000, 3'b000, 9'h000, 16'h0, 16'h0, 0, 16'h0000, 0, 16'hFFFF));
    while (stim.size() > 0) begin
      v = stim.pop_front();
      drive(v);
      sbQ.push_back('{v.expPc, v.expPc + 16'd2, v.expHalt, v.expCnt});
      #1;
      nCmp++;
      if (flush !== v.expFlush) begin nBad++; $display("FAIL sat_flush: flush=%b want %b", flush, v.expFlush); end
      tick();
      e = sbQ.pop_front();
      nCmp++;
      if ({pc, pc_plus2, halted, taken_cnt} !== {e.pc, e.pcp2, e.halted, e.cnt}) begin
        nBad++;
        $display("FAIL sat_wrap: pc=%h p2=%h h=%b cnt=%h want %h %h %b %h", pc, pc_plus2, halted, taken_cnt, e.pc, e.pcp2, e.halted, e.cnt);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_branch_b();
    test_not_taken_then_br();
    test_stall_branch();
    test_halt();
    test_reset_mid_stall();
    test_saturate_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
